// File: rtl/mine_pkg.sv
// Shared constants and types for the Minesweeper board blocks.
package mine_pkg;

    localparam int MINE_BIT = 4;
    localparam int CNT_MSB  = 3;

    // Fibonacci taps 16/14/13/11 expressed as bit positions 15/13/12/10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [4:0]  MINE_WORD    = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLACE_RD,
        S_PLACE_CHK,
        S_CNT_RD,
        S_CNT_WR,
        S_FINISH
    } init_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step enable.
module lfsr16
    import mine_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] state
);

    // Load has priority over stepping; reset restores the default seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= DEFAULT_SEED;
        else if (load)
            state <= load_val;
        else if (step)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/board_init_ctrl.sv
// Board initialiser: clears the RAM, places mines away from the first-click
// cell, then writes each cell's neighbour-mine count.
module board_init_ctrl
    import mine_pkg::*;
#(
    parameter int ROW_W     = 3,
    parameter int COL_W     = 3,
    parameter int NUM_MINES = 10,
    localparam int AW = ROW_W + COL_W,
    localparam int MW = $clog2(NUM_MINES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   seed,
    input  logic [AW-1:0] safe_addr,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] mines_placed,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [4:0]    mem_wdata,
    input  logic [4:0]    mem_rdata
);

    init_state_t      state;
    logic [AW-1:0]    safe_q;
    logic [AW-1:0]    cand_q;
    logic [AW-1:0]    idx;
    logic [3:0]       k;
    logic             pend_nb;
    logic             pend_ctr;
    logic [CNT_MSB:0] acc;
    logic             cell_mine;
    logic             wr_phase;

    logic [15:0]      lfsr_q;
    logic [15:0]      seed_eff;
    logic             accept;
    logic [1:0]       kr;
    logic [1:0]       kc;
    logic [ROW_W:0]   nr;
    logic [COL_W:0]   nc;
    logic             nb_ok;
    logic [AW-1:0]    nb_addr;

    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
    assign accept   = !mem_rdata[MINE_BIT] && (cand_q != safe_q);

    lfsr16 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_IDLE && start),
        .load_val (seed_eff),
        .step     (state == S_PLACE_RD),
        .state    (lfsr_q)
    );

    // Map read slot k to a row-major (dr,dc) offset and the neighbour address.
    // An offset of -1 or +ROWS/COLS both set the extra MSB, flagging out of bounds.
    always_comb begin
        case (k)
            4'd0:    {kr, kc} = 4'b0000;
            4'd1:    {kr, kc} = 4'b0001;
            4'd2:    {kr, kc} = 4'b0010;
            4'd3:    {kr, kc} = 4'b0100;
            4'd5:    {kr, kc} = 4'b0110;
            4'd6:    {kr, kc} = 4'b1000;
            4'd7:    {kr, kc} = 4'b1001;
            4'd8:    {kr, kc} = 4'b1010;
            default: {kr, kc} = 4'b0101;
        endcase
        nr      = (ROW_W+1)'(idx[AW-1:COL_W]) + (ROW_W+1)'(kr) - (ROW_W+1)'(1);
        nc      = (COL_W+1)'(idx[COL_W-1:0])  + (COL_W+1)'(kc) - (COL_W+1)'(1);
        nb_ok   = !nr[ROW_W] && !nc[COL_W];
        nb_addr = {nr[ROW_W-1:0], nc[COL_W-1:0]};
    end

    // RAM port decode from the current state.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_CLEAR: begin
                mem_addr = idx;
                mem_we   = 1'b1;
            end
            S_PLACE_RD:  mem_addr = lfsr_q[AW-1:0];
            S_PLACE_CHK: begin
                mem_addr  = cand_q;
                mem_we    = accept;
                mem_wdata = MINE_WORD;
            end
            S_CNT_RD:    mem_addr = nb_ok ? nb_addr : idx;
            S_CNT_WR: begin
                mem_addr  = idx;
                mem_we    = wr_phase;
                mem_wdata = {cell_mine, cell_mine ? 4'd0 : acc};
            end
            default: ;
        endcase
    end

    // Sequencer; read data is consumed one cycle after its slot via pend_* flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            mines_placed <= '0;
            safe_q       <= '0;
            cand_q       <= '0;
            idx          <= '0;
            k            <= '0;
            pend_nb      <= 1'b0;
            pend_ctr     <= 1'b0;
            acc          <= '0;
            cell_mine    <= 1'b0;
            wr_phase     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        safe_q       <= safe_addr;
                        busy         <= 1'b1;
                        mines_placed <= '0;
                        idx          <= '0;
                        state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == '1)
                        state <= S_PLACE_RD;
                end
                S_PLACE_RD: begin
                    cand_q <= lfsr_q[AW-1:0];
                    state  <= S_PLACE_CHK;
                end
                S_PLACE_CHK: begin
                    state <= S_PLACE_RD;
                    if (accept) begin
                        mines_placed <= mines_placed + 1'b1;
                        if (mines_placed == MW'(NUM_MINES - 1)) begin
                            idx      <= '0;
                            k        <= '0;
                            acc      <= '0;
                            pend_nb  <= 1'b0;
                            pend_ctr <= 1'b0;
                            state    <= S_CNT_RD;
                        end
                    end
                end
                S_CNT_RD: begin
                    if (pend_nb && mem_rdata[MINE_BIT])
                        acc <= acc + 1'b1;
                    if (pend_ctr)
                        cell_mine <= mem_rdata[MINE_BIT];
                    pend_nb  <= nb_ok && (k != 4'd4);
                    pend_ctr <= (k == 4'd4);
                    if (k == 4'd8) begin
                        k        <= '0;
                        wr_phase <= 1'b0;
                        state    <= S_CNT_WR;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_CNT_WR: begin
                    if (!wr_phase) begin
                        if (pend_nb && mem_rdata[MINE_BIT])
                            acc <= acc + 1'b1;
                        if (pend_ctr)
                            cell_mine <= mem_rdata[MINE_BIT];
                        pend_nb  <= 1'b0;
                        pend_ctr <= 1'b0;
                        wr_phase <= 1'b1;
                    end else begin
                        acc      <= '0;
                        wr_phase <= 1'b0;
                        if (idx == '1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_CNT_RD;
                        end
                    end
                end
                S_FINISH: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_init_ctrl.sv
// Self-checking bench for board_init_ctrl with behavioural board model.
module tb_board_init_ctrl;

    localparam int CELLS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_start, a_busy, a_done, a_we;
    logic [15:0] a_seed;
    logic [5:0]  a_safe, a_addr;
    logic [3:0]  a_mp;
    logic [4:0]  a_wdata, a_rdata;

    logic        b_start, b_busy, b_done, b_we;
    logic [15:0] b_seed;
    logic [5:0]  b_safe, b_addr;
    logic [5:0]  b_mp;
    logic [4:0]  b_wdata, b_rdata;

    board_init_ctrl #(.ROW_W(3), .COL_W(3), .NUM_MINES(10)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .seed(a_seed), .safe_addr(a_safe),
        .busy(a_busy), .done(a_done), .mines_placed(a_mp), .mem_addr(a_addr),
        .mem_we(a_we), .mem_wdata(a_wdata), .mem_rdata(a_rdata)
    );

    board_init_ctrl #(.ROW_W(3), .COL_W(3), .NUM_MINES(62)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .seed(b_seed), .safe_addr(b_safe),
        .busy(b_busy), .done(b_done), .mines_placed(b_mp), .mem_addr(b_addr),
        .mem_we(b_we), .mem_wdata(b_wdata), .mem_rdata(b_rdata)
    );

    logic [4:0] ram_a[CELLS];
    logic [4:0] ram_b[CELLS];

    always @(posedge clk) begin
        if (a_we) ram_a[a_addr] <= a_wdata;
        a_rdata <= ram_a[a_addr];
    end

    always @(posedge clk) begin
        if (b_we) ram_b[b_addr] <= b_wdata;
        b_rdata <= ram_b[b_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] exp_board[CELLS];
    int         exp_cands;
    logic [4:0] dump0[CELLS];

    int busy_cyc, we_cnt, done_cnt, clear_run, cnt_cyc, overlap;
    bit finished, clear_open;

    typedef struct {
        logic [15:0] seed;
        logic [5:0]  safe;
        int          exp_mp;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Board model: replay the placement rules, then count neighbours directly.
    task automatic model_build(input logic [15:0] seed, input int safe, input int n);
        logic [15:0] s;
        bit          mine[CELLS];
        int          placed, cand, cnt, rr, cc;
        s = (seed == 16'h0) ? 16'hACE1 : seed;
        exp_cands = 0;
        placed = 0;
        for (int i = 0; i < CELLS; i++) mine[i] = 1'b0;
        while (placed < n && exp_cands < 100000) begin
            cand = int'(s) % CELLS;
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
            exp_cands++;
            if (!mine[cand] && cand != safe) begin
                mine[cand] = 1'b1;
                placed++;
            end
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            if (mine[rr*8 + cc]) cnt++;
                    end
                end
                exp_board[r*8 + c] = mine[r*8 + c] ? 5'b10000 : 5'(cnt);
            end
        end
    endtask

    task automatic run_a(input logic [15:0] seed, input logic [5:0] safe,
                         input int restart_at, input int rst_at);
        int post;
        busy_cyc = 0; we_cnt = 0; done_cnt = 0; clear_run = 0; cnt_cyc = 0;
        overlap = 0; finished = 1'b0; clear_open = 1'b1; post = 0;
        a_seed = seed;
        a_safe = safe;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (a_busy) busy_cyc++;
            if (a_we) we_cnt++;
            if (clear_open) begin
                if (a_we && a_wdata == 5'd0 && int'(a_addr) == clear_run) clear_run++;
                else clear_open = 1'b0;
            end
            if (a_busy && a_mp == 4'd10) cnt_cyc++;
            if (a_done) begin
                done_cnt++;
                finished = 1'b1;
                if (a_busy) overlap++;
            end
            if (finished) begin
                post++;
                if (post > 3) break;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                check("rst_mid_busy", int'(a_busy), 0);
                check("rst_mid_done", int'(a_done), 0);
                check("rst_mid_we", int'(a_we), 0);
                check("rst_mid_mp", int'(a_mp), 0);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            a_start = (c == restart_at);
            @(negedge clk);
        end
        a_start = 1'b0;
        if (!finished) check("a_timeout", 0, 1);
    endtask

    task automatic post_a(input string tag, input logic [5:0] safe, input int exp_mp);
        int diff, mines;
        diff = 0;
        mines = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (ram_a[i] !== exp_board[i]) diff++;
            if (ram_a[i][4]) mines++;
        end
        check({tag, "_mines_placed"}, int'(a_mp), exp_mp);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_busy_overlap"}, overlap, 0);
        check({tag, "_busy_cycles"}, busy_cyc, 64 + 2*exp_cands + 704);
        check({tag, "_write_count"}, we_cnt, 64 + exp_mp + 64);
        check({tag, "_clear_cycles"}, clear_run, 64);
        check({tag, "_count_cycles"}, cnt_cyc, 704);
        check({tag, "_board_diff_cells"}, diff, 0);
        check({tag, "_mine_cells"}, mines, exp_mp);
        check({tag, "_safe_mine_free"}, int'(ram_a[safe][4]), 0);
    endtask

    initial begin
        rst = 1'b0;
        a_start = 1'b0; a_seed = '0; a_safe = '0;
        b_start = 1'b0; b_seed = '0; b_safe = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(a_busy), 0);
        check("reset_done", int'(a_done), 0);
        check("reset_mp", int'(a_mp), 0);
        check("reset_we", int'(a_we), 0);
        check("reset_addr", int'(a_addr), 0);
        check("reset_wdata", int'(a_wdata), 0);
        rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{seed: 16'h1234, safe: 6'd0,  exp_mp: 10};
        vecs[1] = '{seed: 16'hACE1, safe: 6'd63, exp_mp: 10};
        vecs[2] = '{seed: 16'hFFFF, safe: 6'd36, exp_mp: 10};
        vecs[3] = '{seed: 16'h0001, safe: 6'd7,  exp_mp: 10};
        for (int i = 0; i < 4; i++) begin
            model_build(vecs[i].seed, int'(vecs[i].safe), vecs[i].exp_mp);
            run_a(vecs[i].seed, vecs[i].safe, -1, -1);
            post_a($sformatf("vec%0d", i), vecs[i].safe, vecs[i].exp_mp);
        end

        for (int i = 0; i < 3; i++) begin
            logic [15:0] rs;
            logic [5:0]  rsafe;
            rs = 16'($urandom);
            rsafe = 6'($urandom_range(0, 63));
            model_build(rs, int'(rsafe), 10);
            run_a(rs, rsafe, -1, -1);
            post_a($sformatf("rand%0d", i), rsafe, 10);
        end

        // Zero seed must behave exactly like the default seed.
        model_build(16'hACE1, 5, 10);
        run_a(16'h0000, 6'd5, -1, -1);
        post_a("seed0", 6'd5, 10);
        for (int i = 0; i < CELLS; i++) dump0[i] = ram_a[i];
        run_a(16'hACE1, 6'd5, -1, -1);
        post_a("seedACE1", 6'd5, 10);
        begin
            int d;
            d = 0;
            for (int i = 0; i < CELLS; i++) if (dump0[i] !== ram_a[i]) d++;
            check("seed0_vs_ace1_diff", d, 0);
        end

        // start pulses while busy must not restart the sequence.
        model_build(16'h5A5A, 12, 10);
        run_a(16'h5A5A, 6'd12, 10, -1);
        post_a("restart_in_clear", 6'd12, 10);
        run_a(16'h5A5A, 6'd12, 66, -1);
        post_a("restart_in_place", 6'd12, 10);

        // Reset in the middle of the count phase, then a clean run.
        model_build(16'h1234, 0, 10);
        run_a(16'h1234, 6'd0, -1, 64 + 2*exp_cands + 100);
        run_a(16'h1234, 6'd0, -1, -1);
        post_a("after_reset", 6'd0, 10);

        // Dense board on the 62-mine instance.
        model_build(16'hBEEF, 27, 62);
        begin
            int bdone, free, d, post;
            bit fin;
            bdone = 0; fin = 1'b0; post = 0;
            b_seed = 16'hBEEF;
            b_safe = 6'd27;
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            for (int c = 0; c < 30000; c++) begin
                if (b_done) begin
                    bdone++;
                    fin = 1'b1;
                end
                if (fin) begin
                    post++;
                    if (post > 3) break;
                end
                @(negedge clk);
            end
            if (!fin) check("b_timeout", 0, 1);
            free = 0;
            d = 0;
            for (int i = 0; i < CELLS; i++) begin
                if (!ram_b[i][4]) free++;
                if (ram_b[i] !== exp_board[i]) d++;
            end
            check("dense_mines_placed", int'(b_mp), 62);
            check("dense_done_pulses", bdone, 1);
            check("dense_free_cells", free, 2);
            check("dense_safe_mine_free", int'(ram_b[27][4]), 0);
            check("dense_safe_count", int'(ram_b[27][3:0]), int'(exp_board[27][3:0]));
            check("dense_board_diff_cells", d, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
